// File: rtl/time_setting_pkg.sv
// Shared encodings and default timing constants for the time-setting sequencer.
package time_setting_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HR   = 2'd1,
    FIELD_MIN  = 2'd2
  } field_e;

  localparam int unsigned DEFAULT_TIMEOUT_TICKS = 40;
  localparam int unsigned DEFAULT_REPEAT_DELAY  = 2;

endpackage

// File: rtl/inc_repeat.sv
// Increment-button edge detector with press-and-hold auto-repeat on the 4 Hz tick.
module inc_repeat #(
  parameter int unsigned REPEAT_DELAY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic inc_lvl,
  input  logic enable,
  input  logic restart,
  output logic inc_pulse
);

  localparam int CW = $clog2(REPEAT_DELAY + 2);

  logic          prev_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          pulse_q, pulse_d;

  logic rise, held, delay_done, repeat_evt;

  // Repeat only arms on a press seen while enabled, so a press held on entry stays inert.
  always_comb begin
    rise       = inc_lvl & ~prev_q;
    held       = armed_q & inc_lvl;
    delay_done = (hold_q >= CW'(REPEAT_DELAY));
    repeat_evt = held & tick & delay_done & ~restart;

    armed_d = armed_q;
    if (!enable || !inc_lvl) armed_d = 1'b0;
    else if (rise)           armed_d = 1'b1;

    hold_d = hold_q;
    if (!enable || !inc_lvl || restart || rise) hold_d = '0;
    else if (held && tick && !delay_done)       hold_d = hold_q + CW'(1);

    pulse_d = enable & (rise | repeat_evt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      hold_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= inc_lvl;
      armed_q <= armed_d;
      hold_q  <= hold_d;
      pulse_q <= pulse_d;
    end
  end

  assign inc_pulse = pulse_q;

endmodule

// File: rtl/time_setting_ctrl.sv
// Time-setting mode sequencer: field walk, increment enables with auto-repeat,
// commit/cancel strobes and the blink mask for the display.
module time_setting_ctrl
  import time_setting_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
  parameter int unsigned REPEAT_DELAY  = DEFAULT_REPEAT_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode_pb,
  input  logic       next_pb,
  input  logic       inc_lvl,
  output logic       setting,
  output logic [1:0] field,
  output logic       hr_en,
  output logic       min_en,
  output logic       commit,
  output logic       cancel,
  output logic       blink
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_e        state_q;
  field_e        field_q;
  logic          setting_q, hr_en_q, min_en_q, commit_q, cancel_q, blink_q;
  logic [TW-1:0] timer_q;

  logic in_set, timeout_evt, next_evt, inc_evt, inc_pulse;

  // Same-cycle priority: mode > timeout > next > increment; losers are dropped.
  always_comb begin
    in_set      = (state_q == SET_HR) || (state_q == SET_MIN);
    timeout_evt = in_set & ~mode_pb & tick & ~inc_lvl &
                  (timer_q >= TW'(TIMEOUT_TICKS - 1));
    next_evt    = in_set & ~mode_pb & ~timeout_evt & next_pb;
    inc_evt     = in_set & ~mode_pb & ~timeout_evt & ~next_pb & inc_pulse;
  end

  inc_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY)
  ) u_inc_repeat (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .inc_lvl  (inc_lvl),
    .enable   (in_set),
    .restart  (next_evt),
    .inc_pulse(inc_pulse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      field_q   <= FIELD_NONE;
      setting_q <= 1'b0;
      hr_en_q   <= 1'b0;
      min_en_q  <= 1'b0;
      commit_q  <= 1'b0;
      cancel_q  <= 1'b0;
      blink_q   <= 1'b0;
      timer_q   <= '0;
    end else begin
      hr_en_q  <= 1'b0;
      min_en_q <= 1'b0;
      commit_q <= 1'b0;
      cancel_q <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          blink_q <= 1'b0;
          if (mode_pb) begin
            state_q   <= SET_HR;
            field_q   <= FIELD_HR;
            setting_q <= 1'b1;
          end
        end
        SET_HR, SET_MIN: begin
          if (mode_pb || timeout_evt) begin
            state_q   <= IDLE;
            field_q   <= FIELD_NONE;
            setting_q <= 1'b0;
            commit_q  <= mode_pb;
            cancel_q  <= ~mode_pb;
            timer_q   <= '0;
            blink_q   <= 1'b0;
          end else begin
            if (next_evt) begin
              state_q <= (state_q == SET_HR) ? SET_MIN : SET_HR;
              field_q <= (state_q == SET_HR) ? FIELD_MIN : FIELD_HR;
            end
            if (inc_evt) begin
              hr_en_q  <= (state_q == SET_HR);
              min_en_q <= (state_q == SET_MIN);
            end
            if (next_evt || inc_lvl)
              timer_q <= '0;
            else if (tick && (timer_q < TW'(TIMEOUT_TICKS)))
              timer_q <= timer_q + TW'(1);
            // Keep digits solid right after any user action or while the button is held.
            if (next_evt || inc_evt || inc_lvl)
              blink_q <= 1'b0;
            else if (tick)
              blink_q <= ~blink_q;
          end
        end
        default: begin
          state_q   <= IDLE;
          field_q   <= FIELD_NONE;
          setting_q <= 1'b0;
          timer_q   <= '0;
          blink_q   <= 1'b0;
        end
      endcase
    end
  end

  assign setting = setting_q;
  assign field   = field_q;
  assign hr_en   = hr_en_q;
  assign min_en  = min_en_q;
  assign commit  = commit_q;
  assign cancel  = cancel_q;
  assign blink   = blink_q;

endmodule

// File: doc/time_setting_ctrl.md
# time_setting_ctrl

Sequencer for the clock's time-setting mode. It turns debounced push-button inputs into a SET_HR / SET_MIN field walk. It issues one-cycle enable pulses to the hour and minute setting-digit counters, with press-and-hold auto-repeat. It produces commit/cancel strobes for the timekeeping core and a blink mask for the seven-segment driver, and sits between the button conditioning logic and the setting counters.

## Interface
- TIMEOUT_TICKS, 40: ticks of inactivity in a setting state before auto-cancel (10 s at 4 Hz).
- REPEAT_DELAY, 2: ticks an increment button must stay held before auto-repeat starts.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (block is reset while reset==0).
- tick  in  1  one-cycle pulse at 4 Hz from the shared clock divider.
- mode_pb  in  1  one-cycle pulse, debounced mode button.
- next_pb  in  1  one-cycle pulse, debounced next-field button.
- inc_lvl  in  1  debounced level of the increment button (1 = pressed).
- setting  out  1  high while in SET_HR or SET_MIN.
- field  out  2  0 = none, 1 = hour, 2 = minute.
- hr_en  out  1  one-cycle increment enable to the hour setting counter.
- min_en  out  1  one-cycle increment enable to the minute setting counter.
- commit  out  1  one-cycle strobe: load the set value into timekeeping.
- cancel  out  1  one-cycle strobe: discard the set value.
- blink  out  1  1 = blank the digits of the selected field.

## Operation
- FSM states: IDLE, SET_HR, SET_MIN.
- IDLE + mode_pb -> SET_HR.
- SET_HR + next_pb -> SET_MIN.
- SET_MIN + next_pb -> SET_HR (wraps).
- SET_* + mode_pb -> IDLE, pulse commit.
- SET_* + inactivity timer reaching TIMEOUT_TICKS -> IDLE, pulse cancel.
- Same-cycle priority: mode_pb > timeout > next_pb > increment. A lower-priority event in the same cycle is dropped, not queued.
- Increment: a rising edge of inc_lvl (registered previous value) in SET_HR gives one hr_en pulse; in SET_MIN, one min_en pulse. Never both in the same cycle.
- Auto-repeat: while inc_lvl stays high, count ticks. After REPEAT_DELAY ticks, emit one enable per tick until release. A field change while held restarts the repeat delay and targets the new field.
- In IDLE the edge detector still tracks inc_lvl, but edges and repeats are ignored. A press already held on entry to SET_HR produces nothing until it is released and pressed again.
- Inactivity timer: cleared on entry to SET_*, on next_pb, and in every cycle inc_lvl==1. Increments on tick otherwise. Saturates; it is cleared in IDLE.
- Blink: toggles on each tick in SET_*. Forced to 0 for the cycle after any enable pulse or next_pb, so the value stays visible. 0 in IDLE.

## Timing
- All outputs are registered. Reset values: setting=0, field=0, hr_en=0, min_en=0, commit=0, cancel=0, blink=0. FSM=IDLE, all counters 0.
- Event sampled at edge k -> state/field/setting updated at edge k, visible in cycle k..k+1.
- Strobes (commit, cancel, hr_en, min_en) are high for exactly the one cycle after edge k.
- Increment latency: inc_lvl 0->1 sampled at edge k -> enable pulse in cycle after edge k+1 (one edge-detect register plus one output register).
- Repeat pulse follows the qualifying tick by the same 2-edge latency.
- Reset asserted mid-operation: immediate return to IDLE, no commit/cancel strobe, pending pulses dropped.
- commit and cancel are never high together; at most one strobe per cycle of each kind.

## Structure
- Shared package time_setting_pkg: state encodings (IDLE=0, SET_HR=1, SET_MIN=2), field codes (FIELD_NONE/HR/MIN), default TIMEOUT_TICKS and REPEAT_DELAY.
- Sub-module inc_repeat: edge detector plus hold/repeat tick counter. Inputs clk, reset, tick, inc_lvl, enable, restart. Output one-cycle inc_pulse. The top level routes inc_pulse to hr_en or min_en by field.

## Test plan
- Reset, then mode_pb -> setting=1, field=1. A 1-cycle inc_lvl press -> exactly one hr_en pulse 2 cycles after the edge, min_en stays 0.
- SET_HR, next_pb, next_pb -> field goes 2 then 1. Then mode_pb -> one commit pulse, setting=0, field=0.
- SET_MIN, hold inc_lvl for 6 ticks with REPEAT_DELAY=2 -> 1 + 4 = 5 min_en pulses total, blink=0 throughout the hold.
- SET_HR, no activity for 40 ticks -> cancel pulse on the 40th tick's follow-up cycle, commit never asserted, state IDLE.
- mode_pb and next_pb in the same cycle while in SET_MIN -> commit, IDLE, no field change. Reset asserted while in SET_HR with inc held -> all outputs 0 within the reset, no strobe afterwards.
- In IDLE, hold inc_lvl, then mode_pb -> no hr_en until inc_lvl is released and re-pressed.
